// File: rtl/scope_capture_ctrl.sv
// Trigger-armed capture into a back sample bank with double-buffered scan-out.
// The front bank is swapped at frame start once a full capture is waiting.
module scope_capture_ctrl #(
    parameter int DEPTH        = 640,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [7:0] sample_in,
    input  logic [7:0] trig_level,
    input  logic       trig_rising,
    input  logic       run,
    input  logic       frame_start,
    input  logic [9:0] x_in,
    output logic [7:0] data_out,
    output logic       data_vld,
    output logic [1:0] state_out,
    output logic       auto_trig
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((AUTO_TIMEOUT > 0) ? AUTO_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_FILL  = 2'b10,
        S_READY = 2'b11
    } state_t;

    state_t           state_reg;
    logic             front_sel_reg;
    logic             rd_sel_reg;
    logic [PTR_W-1:0] ptr_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             prev_valid_reg;
    logic [7:0]       prev_sample_reg;
    logic             auto_trig_reg;
    logic             data_vld_reg;

    logic             crossing;
    logic             timeout_hit;
    logic             fire;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    logic             wr_bank;
    logic             x_in_range;
    logic [PTR_W-1:0] rd_addr;

    always_comb begin
        crossing = 1'b0;
        if (prev_valid_reg) begin
            if (trig_rising)
                crossing = (prev_sample_reg < trig_level) && (sample_in >= trig_level);
            else
                crossing = (prev_sample_reg > trig_level) && (sample_in <= trig_level);
        end
    end

    assign timeout_hit = (AUTO_TIMEOUT != 0) && (tmo_cnt_reg == TMO_LAST) && !crossing;
    assign fire        = (state_reg == S_ARMED) && run && sample_valid && (crossing || timeout_hit);
    assign wr_en       = fire || ((state_reg == S_FILL) && sample_valid);
    assign wr_addr     = (state_reg == S_FILL) ? ptr_reg : '0;
    assign wr_bank     = ~front_sel_reg;

    assign x_in_range  = (32'(x_in) < 32'(DEPTH));
    assign rd_addr     = x_in_range ? x_in[PTR_W-1:0] : '0;

    // Write port only ever touches the back bank; read port only the front bank.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en && (wr_bank == 1'(gi)))
                    mem[wr_addr] <= sample_in;
            end

            always_ff @(posedge clk) begin
                rd_q <= mem[rd_addr];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            front_sel_reg   <= 1'b0;
            rd_sel_reg      <= 1'b0;
            ptr_reg         <= '0;
            tmo_cnt_reg     <= '0;
            prev_valid_reg  <= 1'b0;
            prev_sample_reg <= 8'd0;
            auto_trig_reg   <= 1'b0;
            data_vld_reg    <= 1'b0;
        end else begin
            data_vld_reg <= x_in_range;
            rd_sel_reg   <= front_sel_reg;

            case (state_reg)
                S_IDLE: begin
                    if (run) begin
                        state_reg      <= S_ARMED;
                        prev_valid_reg <= 1'b0;
                        tmo_cnt_reg    <= '0;
                    end
                end

                S_ARMED: begin
                    if (!run) begin
                        state_reg <= S_IDLE;
                    end else if (sample_valid) begin
                        prev_sample_reg <= sample_in;
                        prev_valid_reg  <= 1'b1;
                        if (fire) begin
                            ptr_reg       <= PTR_W'(1);
                            auto_trig_reg <= !crossing;
                            state_reg     <= S_FILL;
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        end
                    end
                end

                S_FILL: begin
                    if (sample_valid) begin
                        if (ptr_reg == PTR_LAST) begin
                            ptr_reg   <= '0;
                            state_reg <= S_READY;
                        end else begin
                            ptr_reg <= ptr_reg + 1'b1;
                        end
                    end
                end

                S_READY: begin
                    if (frame_start) begin
                        front_sel_reg <= ~front_sel_reg;
                        if (run) begin
                            state_reg      <= S_ARMED;
                            prev_valid_reg <= 1'b0;
                            tmo_cnt_reg    <= '0;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // rd_sel_reg tracks the bank the registered read came from, so a swap lands one cycle after frame_start.
    assign data_out  = data_vld_reg ? (rd_sel_reg ? g_bank[1].rd_q : g_bank[0].rd_q) : 8'd0;
    assign data_vld  = data_vld_reg;
    assign state_out = state_reg;
    assign auto_trig = auto_trig_reg;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl: a capture-level model tracks both banks
// and the expected outputs; literal checks pin the key captured values.
module tb_scope_capture_ctrl;

    localparam int DEPTH = 640;
    localparam int AUTO  = 16;

    logic       clk          = 1'b0;
    logic       rst          = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_in    = 8'd0;
    logic [7:0] trig_level   = 8'd0;
    logic       trig_rising  = 1'b1;
    logic       run          = 1'b0;
    logic       frame_start  = 1'b0;
    logic [9:0] x_in         = 10'd0;
    logic [7:0] data_out;
    logic       data_vld;
    logic [1:0] state_out;
    logic       auto_trig;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    scope_capture_ctrl #(.DEPTH(DEPTH), .AUTO_TIMEOUT(AUTO)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
        .trig_level(trig_level), .trig_rising(trig_rising), .run(run),
        .frame_start(frame_start), .x_in(x_in), .data_out(data_out),
        .data_vld(data_vld), .state_out(state_out), .auto_trig(auto_trig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_ARMED = 1, P_FILL = 2, P_READY = 3;
    logic [7:0] mem   [2][DEPTH];
    bit         known [2][DEPTH];
    int         m_phase, m_written, m_seen;
    bit         m_front, m_have_prev, m_auto, crossed, timed_out;
    logic [7:0] m_prev;
    int         e_data;
    bit         e_vld, e_known;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = P_IDLE; m_front = 0; m_written = 0; m_seen = 0;
            m_have_prev = 0; m_auto = 0; e_vld = 0; e_data = 0; e_known = 1;
        end else begin
            if (int'(x_in) < DEPTH) begin
                e_vld = 1; e_known = known[m_front][x_in]; e_data = int'(mem[m_front][x_in]);
            end else begin
                e_vld = 0; e_known = 1; e_data = 0;
            end
            if (m_phase == P_IDLE) begin
                if (run) begin m_phase = P_ARMED; m_have_prev = 0; m_seen = 0; end
            end else if (m_phase == P_ARMED) begin
                if (!run) m_phase = P_IDLE;
                else if (sample_valid) begin
                    crossed = m_have_prev && (trig_rising ?
                              (m_prev < trig_level && sample_in >= trig_level) :
                              (m_prev > trig_level && sample_in <= trig_level));
                    timed_out = !crossed && (AUTO != 0) && (m_seen + 1 == AUTO);
                    if (crossed || timed_out) begin
                        mem[!m_front][0] = sample_in; known[!m_front][0] = 1;
                        m_written = 1; m_auto = timed_out; m_phase = P_FILL;
                    end else m_seen++;
                    m_prev = sample_in; m_have_prev = 1;
                end
            end else if (m_phase == P_FILL) begin
                if (sample_valid) begin
                    mem[!m_front][m_written] = sample_in; known[!m_front][m_written] = 1;
                    m_written++;
                    if (m_written == DEPTH) begin m_written = 0; m_phase = P_READY; end
                end
            end else begin
                if (frame_start) begin
                    m_front = !m_front;
                    if (run) begin m_phase = P_ARMED; m_have_prev = 0; m_seen = 0; end
                    else m_phase = P_IDLE;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_state", int'(state_out), m_phase);
            chk("cmp_auto", int'(auto_trig), int'(m_auto));
            chk("cmp_vld", int'(data_vld), int'(e_vld));
            if (e_known) chk("cmp_data", int'(data_out), e_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] ramp(input int i);
        return 8'((i % 26) * 10);
    endfunction

    task automatic cyc(input bit v, input logic [7:0] s);
        sample_valid = v;
        sample_in    = s;
        @(posedge clk);
        #2;
        sample_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        cyc(1'b0, 8'd0);
        frame_start = 1'b0;
    endtask

    task automatic read_chk(input string name, input int x, input int exp_d, input bit exp_v);
        x_in = 10'(x);
        cyc(1'b0, 8'd0);
        chk({name, "_data"}, int'(data_out), exp_d);
        chk({name, "_vld"}, int'(data_vld), int'(exp_v));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_state", int'(state_out), 0);
        chk("rst_vld", int'(data_vld), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_auto", int'(auto_trig), 0);

        // Rising trigger on a ramp: first crossing of 128 is sample 130
        trig_level = 8'd128; trig_rising = 1'b1; run = 1'b1;
        cyc(1'b0, 8'd0);
        chk("t1_armed", int'(state_out), 1);
        for (int i = 0; i < 653; i++) begin
            cyc(1'b1, ramp(i));
            if (i == 12) chk("t1_no_trig", int'(state_out), 1);
            if (i == 13) chk("t1_fill", int'(state_out), 2);
        end
        chk("t1_ready", int'(state_out), 3);
        run = 1'b0;
        pulse_frame();
        chk("t1_idle", int'(state_out), 0);
        read_chk("t1_x0", 0, 130, 1);
        read_chk("t1_x1", 1, 140, 1);
        read_chk("t1_x639", 639, 20, 1);

        // Falling trigger with prev gating: 90 (no prev), 120, 95 -> trigger on 95
        trig_rising = 1'b0; trig_level = 8'd100; run = 1'b1; x_in = 10'd0;
        cyc(1'b0, 8'd0);
        cyc(1'b1, 8'd90);  chk("t2_after90", int'(state_out), 1);
        cyc(1'b1, 8'd120); chk("t2_after120", int'(state_out), 1);
        cyc(1'b1, 8'd95);  chk("t2_after95", int'(state_out), 2);
        chk("t2_auto", int'(auto_trig), 0);
        for (int k = 1; k < DEPTH; k++) cyc(1'b1, 8'(k * 7));
        chk("t2_ready", int'(state_out), 3);
        run = 1'b0;
        pulse_frame();
        read_chk("t2_x0", 0, 95, 1);
        read_chk("t2_x1", 1, 7, 1);
        read_chk("t2_x639", 639, 121, 1);

        // Auto-trigger: constant 50 never crosses 200; fires on the 16th sample
        trig_rising = 1'b1; trig_level = 8'd200; run = 1'b1; x_in = 10'd0;
        cyc(1'b0, 8'd0);
        for (int i = 0; i < AUTO - 1; i++) cyc(1'b1, 8'd50);
        chk("t3_pre_auto", int'(state_out), 1);
        cyc(1'b1, 8'd50);
        chk("t3_fill", int'(state_out), 2);
        chk("t3_auto", int'(auto_trig), 1);
        for (int k = 1; k < DEPTH; k++) begin
            x_in = 10'((k * 3) % 1024);
            cyc(1'b1, 8'd50);
        end
        chk("t3_ready", int'(state_out), 3);
        run = 1'b0;
        pulse_frame();
        for (int x = 0; x < DEPTH; x++) begin
            x_in = 10'(x);
            cyc(1'b0, 8'd0);
            chk("t3_all50", int'(data_out), 50);
        end

        // Stop during FILL with gapped samples; frame_start coincides with the final write
        trig_level = 8'd128; run = 1'b1; x_in = 10'd0;
        cyc(1'b0, 8'd0);
        for (int i = 0; i < 13; i++) cyc(1'b1, ramp(i));
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 5) run = 1'b0;
            if (k == DEPTH - 1) frame_start = 1'b1;
            cyc(1'b1, ramp(13 + k));
            frame_start = 1'b0;
            if (k == 300) chk("t4_still_fill", int'(state_out), 2);
            if (k != DEPTH - 1) cyc(1'b0, 8'hff);
        end
        chk("t4_ready", int'(state_out), 3);
        chk("t4_auto_clr", int'(auto_trig), 0);
        read_chk("t4_noswap", 0, 50, 1);
        pulse_frame();
        chk("t4_idle", int'(state_out), 0);
        read_chk("t4_x0", 0, 130, 1);
        read_chk("t4_x5", 5, 180, 1);
        read_chk("t4_x640", 640, 0, 0);
        read_chk("t4_x1000", 1000, 0, 0);

        // Gapped capture aborted by reset at ptr=300; front reverts to bank 0
        run = 1'b1; x_in = 10'd0;
        cyc(1'b0, 8'd0);
        for (int i = 0; i < 13; i++) cyc(1'b1, ramp(i));
        for (int k = 0; k < 300; k++) begin
            cyc(1'b1, ramp(13 + k));
            cyc(1'b0, 8'd0);
        end
        chk("t5_fill", int'(state_out), 2);
        rst = 1'b1;
        #1;
        chk("t5_async", int'(state_out), 0);
        run = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("t5_idle", int'(state_out), 0);
        chk("t5_auto", int'(auto_trig), 0);
        read_chk("t5_x0", 0, 130, 1);
        read_chk("t5_x5", 5, 180, 1);
        read_chk("t5_x1023", 1023, 0, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
